// File: rtl/id_hazard_ctrl_pkg.sv
// id_hazard_ctrl_pkg
//   Shared constants, types and helpers for the ID-stage hazard/forwarding
//   controller.
//   FWD_*    : 2-bit operand forwarding select encodings.
//   ST_*     : stall FSM state encodings.
//   REG_ZERO : hard-wired zero register, which never produces a hazard.
//   reg_match: one stage/operand dependency test.
package id_hazard_ctrl_pkg;

   typedef logic [1:0] fwd_sel_t;
   typedef logic [0:0] state_t;

   localparam fwd_sel_t FWD_RF  = 2'b00;
   localparam fwd_sel_t FWD_MEM = 2'b01;
   localparam fwd_sel_t FWD_WB  = 2'b10;

   localparam state_t ST_RUN   = 1'b0;
   localparam state_t ST_STALL = 1'b1;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A stage matches an operand when it writes a non-zero register that the
   // ID instruction actually reads.
   function automatic logic reg_match(input logic       wr_en,
                                      input logic [4:0] dest,
                                      input logic [4:0] src,
                                      input logic       use_src);
      return wr_en && (dest != REG_ZERO) && (dest == src) && use_src;
   endfunction

endpackage

// File: rtl/id_hazard_ctrl_fwd_sel.sv
// hazard_fwd_sel
//   Forwarding select for one ID-stage operand.
//   src_reg/use_src             : operand register field and its use flag.
//   mem_writeSrc/RegWrite/MemRead: MEM stage destination and control.
//   wb_writeSrc/RegWrite        : WB stage destination and control.
//   fwd_sel                     : FWD_RF, FWD_MEM or FWD_WB.
module hazard_fwd_sel
   import id_hazard_ctrl_pkg::*;
(
   input  logic [4:0] src_reg,
   input  logic       use_src,
   input  logic [4:0] mem_writeSrc,
   input  logic       mem_RegWrite,
   input  logic       mem_MemRead,
   input  logic [4:0] wb_writeSrc,
   input  logic       wb_RegWrite,
   output logic [1:0] fwd_sel
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = reg_match(mem_RegWrite, mem_writeSrc, src_reg, use_src);
   assign wb_hit  = reg_match(wb_RegWrite, wb_writeSrc, src_reg, use_src);

   // A load sitting in MEM has no data yet; it must not fall through to an
   // older WB copy of the same register either, so it selects the RF and
   // relies on the stall logic.
   always_comb begin
      fwd_sel = FWD_RF;
      if (mem_hit) begin
         if (!mem_MemRead) fwd_sel = FWD_MEM;
      end else if (wb_hit) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl
//   ID-stage hazard and forwarding controller. State updates on the falling
//   edge of CLK; RST is asynchronous active-high.
//   id_*                 : ID instruction source fields, use flags, branch/jr.
//   branch_taken         : redirect resolved in ID.
//   exe_*/mem_*/wb_*     : downstream destination registers and controls.
//   forward_ID_A/B       : operand forwarding selects.
//   PC_write/IF_ID_write : front-end enables (low while stalling).
//   IF_ID_Flush          : squash fetched instruction on redirect.
//   ID_EXE_Flush         : bubble into ID/EXE while stalling.
//   stall_cycles/flush_events : saturating activity counters.
module id_hazard_ctrl
   import id_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_useRs,
   input  logic             id_useRt,
   input  logic             id_isBranch,
   input  logic             id_isJr,
   input  logic             branch_taken,
   input  logic [4:0]       exe_writeSrc,
   input  logic             exe_RegWrite,
   input  logic             exe_MemRead,
   input  logic [4:0]       mem_writeSrc,
   input  logic             mem_RegWrite,
   input  logic             mem_MemRead,
   input  logic [4:0]       wb_writeSrc,
   input  logic             wb_RegWrite,
   output logic [1:0]       forward_ID_A,
   output logic [1:0]       forward_ID_B,
   output logic             PC_write,
   output logic             IF_ID_write,
   output logic             IF_ID_Flush,
   output logic             ID_EXE_Flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   state_t           state_q, state_d;
   logic [1:0]       rem_q, rem_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_events_q, flush_events_d;

   logic [1:0] fwd_a, fwd_b;
   logic       exe_hit, mem_hit, brj, exe_load;
   logic [1:0] need;
   logic       stall;
   logic       if_id_flush_int;

   hazard_fwd_sel u_fwd_a (
      .src_reg      (id_rs),
      .use_src      (id_useRs),
      .mem_writeSrc (mem_writeSrc),
      .mem_RegWrite (mem_RegWrite),
      .mem_MemRead  (mem_MemRead),
      .wb_writeSrc  (wb_writeSrc),
      .wb_RegWrite  (wb_RegWrite),
      .fwd_sel      (fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .src_reg      (id_rt),
      .use_src      (id_useRt),
      .mem_writeSrc (mem_writeSrc),
      .mem_RegWrite (mem_RegWrite),
      .mem_MemRead  (mem_MemRead),
      .wb_writeSrc  (wb_writeSrc),
      .wb_RegWrite  (wb_RegWrite),
      .fwd_sel      (fwd_b)
   );

   assign exe_hit = reg_match(exe_RegWrite, exe_writeSrc, id_rs, id_useRs) ||
                    reg_match(exe_RegWrite, exe_writeSrc, id_rt, id_useRt);
   assign mem_hit = reg_match(mem_RegWrite, mem_writeSrc, id_rs, id_useRs) ||
                    reg_match(mem_RegWrite, mem_writeSrc, id_rt, id_useRt);
   assign brj      = id_isBranch || id_isJr;
   assign exe_load = exe_hit && exe_MemRead;

   // Checked from largest to smallest so the maximum applicable need wins;
   // an EXE hit therefore decides before any MEM hit on the same operand.
   always_comb begin
      need = 2'd0;
      if (brj && exe_load)                   need = 2'd2;
      else if (exe_load)                     need = 2'd1;
      else if (brj && exe_hit)               need = 2'd1;
      else if (brj && mem_hit && mem_MemRead) need = 2'd1;
   end

   // A held stall is not re-evaluated; only RUN looks at need.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      stall   = 1'b0;
      if (state_q == ST_STALL) begin
         stall = 1'b1;
         rem_d = rem_q - 2'd1;
         if (rem_q == 2'd1) state_d = ST_RUN;
      end else if (need != 2'd0) begin
         stall = 1'b1;
         if (need == 2'd2) begin
            state_d = ST_STALL;
            rem_d   = need - 2'd1;
         end
      end
   end

   assign if_id_flush_int = !stall && branch_taken;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (stall && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (if_id_flush_int && (flush_events_q != '1))
         flush_events_d = flush_events_q + CNT_W'(1);
   end

   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         state_q        <= ST_RUN;
         rem_q          <= 2'd0;
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         state_q        <= state_d;
         rem_q          <= rem_d;
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   always_comb begin
      if (RST) begin
         forward_ID_A = FWD_RF;
         forward_ID_B = FWD_RF;
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EXE_Flush = 1'b1;
         IF_ID_Flush  = 1'b1;
      end else begin
         forward_ID_A = fwd_a;
         forward_ID_B = fwd_b;
         PC_write     = !stall;
         IF_ID_write  = !stall;
         ID_EXE_Flush = stall;
         IF_ID_Flush  = if_id_flush_int;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

   localparam int CNT_W = 4;

   logic             CLK = 1'b0;
   logic             RST;
   logic [4:0]       id_rs, id_rt;
   logic             id_useRs, id_useRt, id_isBranch, id_isJr, branch_taken;
   logic [4:0]       exe_writeSrc, mem_writeSrc, wb_writeSrc;
   logic             exe_RegWrite, exe_MemRead, mem_RegWrite, mem_MemRead, wb_RegWrite;
   logic [1:0]       forward_ID_A, forward_ID_B;
   logic             PC_write, IF_ID_write, IF_ID_Flush, ID_EXE_Flush;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   int checks = 0;
   int errors = 0;

   id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
      .id_isBranch(id_isBranch), .id_isJr(id_isJr), .branch_taken(branch_taken),
      .exe_writeSrc(exe_writeSrc), .exe_RegWrite(exe_RegWrite), .exe_MemRead(exe_MemRead),
      .mem_writeSrc(mem_writeSrc), .mem_RegWrite(mem_RegWrite), .mem_MemRead(mem_MemRead),
      .wb_writeSrc(wb_writeSrc), .wb_RegWrite(wb_RegWrite),
      .forward_ID_A(forward_ID_A), .forward_ID_B(forward_ID_B),
      .PC_write(PC_write), .IF_ID_write(IF_ID_write),
      .IF_ID_Flush(IF_ID_Flush), .ID_EXE_Flush(ID_EXE_Flush),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Control outputs as {PC_write, IF_ID_write, ID_EXE_Flush, IF_ID_Flush}.
   task automatic check_ctl(input string tag, input logic [3:0] exp);
      check(tag, {12'd0, PC_write, IF_ID_write, ID_EXE_Flush, IF_ID_Flush}, {12'd0, exp});
   endtask

   task automatic clear_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_useRs = 1'b0; id_useRt = 1'b0;
      id_isBranch = 1'b0; id_isJr = 1'b0; branch_taken = 1'b0;
      exe_writeSrc = 5'd0; exe_RegWrite = 1'b0; exe_MemRead = 1'b0;
      mem_writeSrc = 5'd0; mem_RegWrite = 1'b0; mem_MemRead = 1'b0;
      wb_writeSrc = 5'd0; wb_RegWrite = 1'b0;
   endtask

   // Advance past the next falling (active) edge, then settle.
   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1;
      clear_inputs();
      #2;
      check_ctl("reset_ctl", 4'b0011);
      check("reset_fwdA", {14'd0, forward_ID_A}, 16'h0);
      check("reset_stall_cnt", {12'd0, stall_cycles}, 16'h0);
      check("reset_flush_cnt", {12'd0, flush_events}, 16'h0);
      tick();
      RST = 1'b0;

      // MEM ALU forward to A
      id_rs = 5'd3; id_useRs = 1'b1;
      mem_writeSrc = 5'd3; mem_RegWrite = 1'b1;
      #1;
      check("fwdA_mem", {14'd0, forward_ID_A}, 16'h1);
      check("fwdB_unused", {14'd0, forward_ID_B}, 16'h0);
      check_ctl("fwd_no_stall", 4'b1100);
      tick();
      // WB only
      mem_RegWrite = 1'b0; wb_writeSrc = 5'd3; wb_RegWrite = 1'b1;
      #1;
      check("fwdA_wb", {14'd0, forward_ID_A}, 16'h2);
      tick();
      // MEM and WB both: MEM wins, also on B
      mem_RegWrite = 1'b1; id_rt = 5'd3; id_useRt = 1'b1;
      #1;
      check("fwdA_mem_over_wb", {14'd0, forward_ID_A}, 16'h1);
      check("fwdB_mem_over_wb", {14'd0, forward_ID_B}, 16'h1);
      check("no_stall_cnt", {12'd0, stall_cycles}, 16'h0);
      tick();

      // Load-use: lw $5 in EXE, add reads rt=5 -> one stall
      clear_inputs();
      id_rt = 5'd5; id_useRt = 1'b1;
      exe_writeSrc = 5'd5; exe_RegWrite = 1'b1; exe_MemRead = 1'b1;
      #1;
      check_ctl("loaduse_stall", 4'b0010);
      tick();
      check("loaduse_cnt", {12'd0, stall_cycles}, 16'h1);
      exe_RegWrite = 1'b0; exe_MemRead = 1'b0;
      mem_writeSrc = 5'd5; mem_RegWrite = 1'b1; mem_MemRead = 1'b1;
      #1;
      check_ctl("loaduse_resume", 4'b1100);
      check("loaduse_mem_no_fwd", {14'd0, forward_ID_B}, 16'h0);
      tick();
      check("loaduse_cnt_hold", {12'd0, stall_cycles}, 16'h1);
      mem_RegWrite = 1'b0; mem_MemRead = 1'b0;
      wb_writeSrc = 5'd5; wb_RegWrite = 1'b1;
      #1;
      check("loaduse_wb_fwd", {14'd0, forward_ID_B}, 16'h2);
      tick();

      // lw $7 in EXE, beq rs=7 -> two stalls through STALL
      clear_inputs();
      id_rs = 5'd7; id_useRs = 1'b1; id_useRt = 1'b1; id_isBranch = 1'b1;
      exe_writeSrc = 5'd7; exe_RegWrite = 1'b1; exe_MemRead = 1'b1;
      #1;
      check_ctl("br_load_stall1", 4'b0010);
      tick();
      check("br_load_cnt1", {12'd0, stall_cycles}, 16'h2);
      // Held stall ignores inputs, and suppresses the redirect flush
      clear_inputs();
      branch_taken = 1'b1;
      #1;
      check_ctl("br_load_stall2", 4'b0010);
      tick();
      check("br_load_cnt2", {12'd0, stall_cycles}, 16'h3);
      check("flush_cnt_after_stall", {12'd0, flush_events}, 16'h0);
      #1;
      check_ctl("br_taken_run", 4'b1101);
      tick();
      check("flush_cnt_one", {12'd0, flush_events}, 16'h1);
      branch_taken = 1'b0;
      #1;
      check_ctl("flush_one_cycle", 4'b1100);

      // Branch with ALU result in EXE -> one stall
      id_rs = 5'd9; id_useRs = 1'b1; id_isBranch = 1'b1;
      exe_writeSrc = 5'd9; exe_RegWrite = 1'b1;
      #1;
      check_ctl("br_exe_alu_stall", 4'b0010);
      tick();
      // jr with load in MEM -> one stall
      clear_inputs();
      id_rs = 5'd9; id_useRs = 1'b1; id_isJr = 1'b1;
      mem_writeSrc = 5'd9; mem_RegWrite = 1'b1; mem_MemRead = 1'b1;
      #1;
      check_ctl("jr_mem_load_stall", 4'b0010);
      check("jr_mem_load_fwd", {14'd0, forward_ID_A}, 16'h0);
      tick();
      check("stall_cnt_5", {12'd0, stall_cycles}, 16'h5);

      // Register $0 never matches
      clear_inputs();
      id_isBranch = 1'b1; id_useRs = 1'b1; id_useRt = 1'b1;
      exe_RegWrite = 1'b1; exe_MemRead = 1'b1;
      mem_RegWrite = 1'b1; wb_RegWrite = 1'b1;
      #1;
      check_ctl("zero_no_stall", 4'b1100);
      check("zero_no_fwd", {12'd0, forward_ID_A, forward_ID_B}, 16'h0);
      tick();

      // Reset during the first cycle of a 2-cycle stall
      clear_inputs();
      id_rs = 5'd7; id_useRs = 1'b1; id_isBranch = 1'b1;
      exe_writeSrc = 5'd7; exe_RegWrite = 1'b1; exe_MemRead = 1'b1;
      tick();
      check("pre_reset_cnt", {12'd0, stall_cycles}, 16'h6);
      RST = 1'b1;
      #1;
      check_ctl("mid_stall_reset_ctl", 4'b0011);
      check("mid_stall_reset_cnt", {12'd0, stall_cycles}, 16'h0);
      check("mid_stall_reset_fwd", {14'd0, forward_ID_A}, 16'h0);
      tick();
      clear_inputs();
      RST = 1'b0;
      #1;
      check_ctl("post_reset_run", 4'b1100);
      tick();
      check("post_reset_cnt", {12'd0, stall_cycles}, 16'h0);

      // Saturation: held load-use stalls every cycle
      id_rt = 5'd4; id_useRt = 1'b1;
      exe_writeSrc = 5'd4; exe_RegWrite = 1'b1; exe_MemRead = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      check("sat_reach_max", {12'd0, stall_cycles}, 16'hF);
      for (int i = 0; i < 3; i++) tick();
      check("sat_hold_max", {12'd0, stall_cycles}, 16'hF);
      check_ctl("sat_still_stalling", 4'b0010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
Hazard and forwarding controller for the ID stage of the pipelined CPU. It drives the control inputs of the ID/EXE pipeline register:
- forward_ID_A/B: ID-stage operand forwarding selects.
- ID_EXE_Flush: bubble insertion.
It also drives the PC and IF/ID write-enables and the IF/ID flush used for branch/jump redirect. A small FSM holds multi-cycle stalls for load-use and branch/jr operand hazards, and two saturating counters record stall and flush activity.

Parameters:
CNT_W, 16, width of the performance counters stall_cycles and flush_events.

Ports:
CLK  in  1  clock; all state updates on the falling edge, matching the pipeline registers.
RST  in  1  asynchronous, active-high reset.
id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
id_useRs, id_useRt  in  1 each  instruction in ID reads rs / rt.
id_isBranch  in  1  ID instruction is beq/bne/bltz-type (both operands compared in ID).
id_isJr  in  1  ID instruction is jr (rs needed in ID).
branch_taken  in  1  resolved branch taken (zero & branch) or jump/jr in ID.
exe_writeSrc  in  5  EXE destination register.
exe_RegWrite, exe_MemRead  in  1 each  EXE control.
mem_writeSrc  in  5  MEM destination register.
mem_RegWrite, mem_MemRead  in  1 each  MEM control.
wb_writeSrc  in  5  WB destination register.
wb_RegWrite  in  1  WB control.
forward_ID_A, forward_ID_B  out  2 each  00 register file, 01 MEM forward, 10 WB forward; 11 is never driven.
PC_write  out  1  PC update enable.
IF_ID_write  out  1  IF/ID register enable.
IF_ID_Flush  out  1  squash the fetched instruction.
ID_EXE_Flush  out  1  insert a bubble into ID/EXE.
stall_cycles  out  CNT_W  saturating count of stalled cycles.
flush_events  out  CNT_W  saturating count of IF_ID_Flush assertions.

Behaviour:
- Match rule: a stage "matches" operand X if its RegWrite=1, its dest≠0, its dest==X, and the ID instruction uses X.
- Forwarding (combinational, independent of FSM state):
  - MEM match with mem_MemRead=0 → 01.
  - Else WB match → 10.
  - Else 00.
  - MEM has priority over WB.
  - A MEM load match never forwards from MEM; the stall rules below cover it.
- Stall need, evaluated in RUN:
  - need=2: id_isBranch|id_isJr and EXE match with exe_MemRead=1.
  - need=1: any instruction with EXE match and exe_MemRead=1 (load-use).
  - need=1: branch/jr with EXE match and exe_MemRead=0.
  - need=1: branch/jr with MEM match and mem_MemRead=1.
  - need=0: otherwise. The maximum applicable need is used.
- FSM states: RUN, STALL. Counter rem is 2 bits.
  - RUN, need>0: this cycle stalls; next state STALL with rem=need-1 if need=2, else stay RUN.
  - STALL: this cycle stalls; rem decrements; go to RUN when rem reaches 0.
  - A held stall is not re-evaluated. The next RUN cycle re-evaluates and may stall again.
- Stall cycle outputs: PC_write=0, IF_ID_write=0, ID_EXE_Flush=1, IF_ID_Flush=0.
- Non-stall cycle outputs: PC_write=1, IF_ID_write=1, ID_EXE_Flush=0, IF_ID_Flush=branch_taken.
- Priority: a stall suppresses IF_ID_Flush, because branch_taken is not valid until operands are ready.
- Counters:
  - stall_cycles increments on every stall cycle.
  - flush_events increments on every cycle with IF_ID_Flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset values (RST high, async, also mid-stall):
  - state=RUN, rem=0, counters=0.
  - While RST=1, outputs are forced: PC_write=0, IF_ID_write=0, ID_EXE_Flush=1, IF_ID_Flush=1, forward_ID_A/B=00.
  - The first falling edge after release evaluates normally.
- Register $0 never matches, so no stall and no forward.
- A simultaneous EXE and MEM match on the same operand is resolved by the EXE rule. The stall waits until the newest producer reaches the forwardable stage.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - State encoding ST_RUN/ST_STALL.
  - REG_ZERO=5'd0.
- Sub-module hazard_fwd_sel: one operand's 2-bit select from reg/use flag and MEM/WB fields. Instantiated twice, for A and B.

Test Plan:
- add $3 in MEM (mem_RegWrite=1, MemRead=0), ID uses rs=3 → forward_ID_A=01, no stall. Same with $3 only in WB → 10. Both MEM and WB write $3 → 01.
- lw $5 in EXE, ID add with rt=5 → exactly 1 stall cycle (PC_write=0, ID_EXE_Flush=1, stall_cycles=1). Next cycle with lw in MEM and RegWrite=1, MemRead=1 → no stall, forward_ID_B=00. Then with lw in WB → forward_ID_B=10.
- lw $7 in EXE, ID beq rs=7 → 2 consecutive stall cycles via STALL state, then PC_write=1; stall_cycles=2.
- Branch with EXE/MEM dest=0 and RegWrite=1 → no stall, forward 00. branch_taken=1 in RUN → IF_ID_Flush=1 for one cycle, flush_events=1. branch_taken=1 during a stall cycle → IF_ID_Flush=0.
- Assert RST in the first cycle of a 2-cycle stall → immediate forced reset outputs, counters 0. After release with no hazard → PC_write=1, state RUN.
- Force stall_cycles to 16'hFFFF via a long stall sequence (CNT_W=4 build: 15) → it stays at max on further stalls.
